// File: rtl/umi_to_sb_packer.sv
// UMI-to-switchboard transmit bridge: packs each UMI beat into one flit and buffers it in a
// small FIFO, deriving the routing destination and the end-of-message flag on entry.
module umi_to_sb_packer #(
    parameter int unsigned DW       = 256,
    parameter int unsigned AW       = 64,
    parameter int unsigned CW       = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEST_LSB = 40,
    parameter int unsigned EOM_BIT  = 22
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      umi_valid,
    output logic                      umi_ready,
    input  logic [CW-1:0]             umi_cmd,
    input  logic [AW-1:0]             umi_dstaddr,
    input  logic [AW-1:0]             umi_srcaddr,
    input  logic [DW-1:0]             umi_data,
    output logic                      sb_valid,
    input  logic                      sb_ready,
    output logic [DW+2*AW+CW-1:0]     sb_data,
    output logic [31:0]               sb_dest,
    output logic                      sb_last,
    output logic [$clog2(DEPTH):0]    level,
    output logic [31:0]               pkt_count
);

    localparam int unsigned FW = DW + 2 * AW + CW;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [FW-1:0]    data_mem [DEPTH];
    logic [31:0]      dest_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   pkt_count_q, pkt_count_d;

    logic          push;
    logic          pop;
    logic [31:0]   dest_in;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign umi_ready = (level_q != LW'(DEPTH));
    assign sb_valid  = (level_q != '0);
    assign push      = umi_valid && umi_ready;
    assign pop       = sb_valid && sb_ready;

    // Shifting zero-fills destination bits that lie above the top of dstaddr.
    assign dest_in   = 32'(umi_dstaddr >> DEST_LSB);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        pkt_count_d = pkt_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (last_mem[rd_ptr_q]) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Storage is not reset; contents are only observable while level is non-zero.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            data_mem[wr_ptr_q] <= {umi_data, umi_srcaddr, umi_dstaddr, umi_cmd};
            dest_mem[wr_ptr_q] <= dest_in;
            last_mem[wr_ptr_q] <= umi_cmd[EOM_BIT];
        end
    end

    assign sb_data   = data_mem[rd_ptr_q];
    assign sb_dest   = dest_mem[rd_ptr_q];
    assign sb_last   = last_mem[rd_ptr_q];
    assign level     = level_q;
    assign pkt_count = pkt_count_q;

endmodule
